// File: rtl/writeback_unit.sv
// Writeback front end: per-lane result FIFOs, same-cycle rd collision ordering, registered RF write ports.
// Optional macro WB_CONFLICT_CNT_EN adds a saturating collision-hold counter output conflict_cnt.
module writeback_unit #(
  parameter int LANE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_res_valid,
  output logic        lsu_res_ready,
  input  logic [4:0]  lsu_res_rd,
  input  logic [31:0] lsu_res_data,
  input  logic        ixu1_res_valid,
  output logic        ixu1_res_ready,
  input  logic [4:0]  ixu1_res_rd,
  input  logic [31:0] ixu1_res_data,
  input  logic        ixu2_res_valid,
  output logic        ixu2_res_ready,
  input  logic [4:0]  ixu2_res_rd,
  input  logic [31:0] ixu2_res_data,
  input  logic        branch_res_valid,
  output logic        branch_res_ready,
  input  logic [4:0]  branch_res_rd,
  input  logic [31:0] branch_res_data,
  output logic [4:0]  lsu_rd,
  output logic [31:0] lsu_wr_data,
  output logic        lsu_wr_en,
  output logic [4:0]  ixu1_rd,
  output logic [31:0] ixu1_wr_data,
  output logic        ixu1_wr_en,
  output logic [4:0]  ixu2_rd,
  output logic [31:0] ixu2_wr_data,
  output logic        ixu2_wr_en,
  output logic [4:0]  branch_rd,
  output logic [31:0] branch_wr_data,
  output logic        branch_wr_en,
`ifdef WB_CONFLICT_CNT_EN
  output logic [15:0] conflict_cnt,
`endif
  output logic [31:0] pending_mask
);

  localparam int NL = 4;
  localparam int PW = (LANE_DEPTH > 1) ? $clog2(LANE_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [NL-1:0] w_in_valid;
  logic [4:0]    w_in_rd   [NL];
  logic [31:0]   w_in_data [NL];
  logic [NL-1:0] w_ready;
  logic [NL-1:0] w_push;
  logic [NL-1:0] w_pop;
  logic [NL-1:0] w_issue;
  logic [NL-1:0] w_held;
  logic [NL-1:0] w_head_valid;
  logic [4:0]    w_head_rd   [NL];
  logic [31:0]   w_head_data [NL];

  logic [4:0]    r_mem_rd   [NL][LANE_DEPTH];
  logic [31:0]   r_mem_data [NL][LANE_DEPTH];
  logic [PW-1:0] r_wptr  [NL];
  logic [PW-1:0] r_rptr  [NL];
  logic [CW-1:0] r_count [NL];
  logic [NL-1:0] r_wr_en;
  logic [4:0]    r_rd      [NL];
  logic [31:0]   r_wr_data [NL];

  assign w_in_valid   = {branch_res_valid, ixu2_res_valid, ixu1_res_valid, lsu_res_valid};
  assign w_in_rd[0]   = lsu_res_rd;
  assign w_in_rd[1]   = ixu1_res_rd;
  assign w_in_rd[2]   = ixu2_res_rd;
  assign w_in_rd[3]   = branch_res_rd;
  assign w_in_data[0] = lsu_res_data;
  assign w_in_data[1] = ixu1_res_data;
  assign w_in_data[2] = ixu2_res_data;
  assign w_in_data[3] = branch_res_data;

  // Ready comes from the registered count only, so a full lane never accepts even if it pops this cycle.
  always_comb begin
    for (int l = 0; l < NL; l++) begin
      w_ready[l]      = ~rst & (r_count[l] < CW'(LANE_DEPTH));
      w_push[l]       = w_in_valid[l] & w_ready[l];
      w_head_valid[l] = (r_count[l] != {CW{1'b0}});
      w_head_rd[l]    = r_mem_rd[l][r_rptr[l]];
      w_head_data[l]  = r_mem_data[l][r_rptr[l]];
    end
  end

  // Head arbitration: a head waits while any lower-index lane holds a head to the same rd.
  always_comb begin
    logic w_coll;
    w_issue = '0;
    w_pop   = '0;
    w_held  = '0;
    for (int l = 0; l < NL; l++) begin
      w_coll = 1'b0;
      for (int k = 0; k < NL; k++) begin
        if (k < l && w_head_valid[k] && (w_head_rd[k] == w_head_rd[l])) begin
          w_coll = 1'b1;
        end else begin
          w_coll = w_coll;
        end
      end
      if (!w_head_valid[l]) begin
        w_pop[l] = 1'b0;
      end else if (w_head_rd[l] == 5'd0) begin
        w_pop[l] = 1'b1;
      end else if (!w_coll) begin
        w_issue[l] = 1'b1;
        w_pop[l]   = 1'b1;
      end else begin
        w_held[l] = 1'b1;
      end
    end
  end

  // FIFO storage, no reset needed: occupancy is tracked by the pointer/count registers.
  always_ff @(posedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (w_push[l]) begin
        r_mem_rd[l][r_wptr[l]]   <= w_in_rd[l];
        r_mem_data[l][r_wptr[l]] <= w_in_data[l];
      end
    end
  end

  // FIFO pointers, occupancy and registered write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < NL; l++) begin
        r_wptr[l]    <= {PW{1'b0}};
        r_rptr[l]    <= {PW{1'b0}};
        r_count[l]   <= {CW{1'b0}};
        r_rd[l]      <= 5'd0;
        r_wr_data[l] <= 32'd0;
      end
      r_wr_en <= '0;
    end else begin
      for (int l = 0; l < NL; l++) begin
        if (w_push[l]) r_wptr[l] <= r_wptr[l] + PW'(1);
        if (w_pop[l])  r_rptr[l] <= r_rptr[l] + PW'(1);
        case ({w_push[l], w_pop[l]})
          2'b10:   r_count[l] <= r_count[l] + CW'(1);
          2'b01:   r_count[l] <= r_count[l] - CW'(1);
          default: r_count[l] <= r_count[l];
        endcase
        r_wr_en[l] <= w_issue[l];
        if (w_issue[l]) begin
          r_rd[l]      <= w_head_rd[l];
          r_wr_data[l] <= w_head_data[l];
        end
      end
    end
  end

  // Pending mask: every live FIFO slot plus every write currently on the RF ports.
  always_comb begin
    logic [31:0]   w_mask;
    logic [PW-1:0] w_off;
    w_mask = 32'd0;
    for (int l = 0; l < NL; l++) begin
      for (int i = 0; i < LANE_DEPTH; i++) begin
        w_off = PW'(i) - r_rptr[l];
        if ({1'b0, w_off} < r_count[l]) begin
          w_mask[r_mem_rd[l][i]] = 1'b1;
        end else begin
          w_mask = w_mask;
        end
      end
      if (r_wr_en[l]) begin
        w_mask[r_rd[l]] = 1'b1;
      end else begin
        w_mask = w_mask;
      end
    end
    w_mask[0]    = 1'b0;
    pending_mask = w_mask;
  end

`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] r_conflict_cnt;
  // Counts cycles with at least one collision hold, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conflict_cnt <= 16'd0;
    end else if ((|w_held) && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end
  assign conflict_cnt = r_conflict_cnt;
`endif

  assign lsu_res_ready    = w_ready[0];
  assign ixu1_res_ready   = w_ready[1];
  assign ixu2_res_ready   = w_ready[2];
  assign branch_res_ready = w_ready[3];
  assign lsu_wr_en        = r_wr_en[0];
  assign ixu1_wr_en       = r_wr_en[1];
  assign ixu2_wr_en       = r_wr_en[2];
  assign branch_wr_en     = r_wr_en[3];
  assign lsu_rd           = r_rd[0];
  assign ixu1_rd          = r_rd[1];
  assign ixu2_rd          = r_rd[2];
  assign branch_rd        = r_rd[3];
  assign lsu_wr_data      = r_wr_data[0];
  assign ixu1_wr_data     = r_wr_data[1];
  assign ixu2_wr_data     = r_wr_data[2];
  assign branch_wr_data   = r_wr_data[3];

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: vector table for single bundles plus hand sequences for collisions and reset.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  res_valid = 4'd0;
  logic [4:0]  res_rd   [4];
  logic [31:0] res_data [4];
  logic [3:0]  res_ready;
  logic [3:0]  wr_en;
  logic [4:0]  rd_o   [4];
  logic [31:0] data_o [4];
  logic [31:0] pending_mask;
`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  always #5 clk = ~clk;

  writeback_unit #(.LANE_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .lsu_res_valid(res_valid[0]),    .lsu_res_ready(res_ready[0]),
    .lsu_res_rd(res_rd[0]),          .lsu_res_data(res_data[0]),
    .ixu1_res_valid(res_valid[1]),   .ixu1_res_ready(res_ready[1]),
    .ixu1_res_rd(res_rd[1]),         .ixu1_res_data(res_data[1]),
    .ixu2_res_valid(res_valid[2]),   .ixu2_res_ready(res_ready[2]),
    .ixu2_res_rd(res_rd[2]),         .ixu2_res_data(res_data[2]),
    .branch_res_valid(res_valid[3]), .branch_res_ready(res_ready[3]),
    .branch_res_rd(res_rd[3]),       .branch_res_data(res_data[3]),
    .lsu_rd(rd_o[0]),    .lsu_wr_data(data_o[0]),    .lsu_wr_en(wr_en[0]),
    .ixu1_rd(rd_o[1]),   .ixu1_wr_data(data_o[1]),   .ixu1_wr_en(wr_en[1]),
    .ixu2_rd(rd_o[2]),   .ixu2_wr_data(data_o[2]),   .ixu2_wr_en(wr_en[2]),
    .branch_rd(rd_o[3]), .branch_wr_data(data_o[3]), .branch_wr_en(wr_en[3]),
`ifdef WB_CONFLICT_CNT_EN
    .conflict_cnt(conflict_cnt),
`endif
    .pending_mask(pending_mask)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] regs [32];
  int          log_lane [$];
  logic [4:0]  log_rd   [$];
  logic [31:0] log_data [$];
  int          log_cyc  [$];

  // Register-file model and write log, sampled at the edge that performs the write.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int l = 0; l < 4; l++) begin
      if (wr_en[l]) begin
        regs[rd_o[l]] = data_o[l];
        log_lane.push_back(l);
        log_rd.push_back(rd_o[l]);
        log_data.push_back(data_o[l]);
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    log_lane.delete(); log_rd.delete(); log_data.delete(); log_cyc.delete();
  endtask

  task automatic idle_inputs();
    res_valid = 4'd0;
    for (int l = 0; l < 4; l++) begin
      res_rd[l] = 5'd0;
      res_data[l] = 32'd0;
    end
  endtask

  typedef struct packed {
    logic [3:0]        valid;
    logic [3:0][4:0]   rd;
    logic [3:0][31:0]  data;
    logic [3:0]        exp_en;
    logic [31:0]       exp_pend;
  } vec_t;

  vec_t vecs [5];
  int   idx [4];
  bit   ready_low_seen;
  int   exp_lane [$];
  logic [31:0] exp_data [$];

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    for (int i = 0; i < 5; i++) vecs[i] = '0;
    vecs[0].valid = 4'b0010; vecs[0].rd[1] = 5'd5; vecs[0].data[1] = 32'h11;
    vecs[0].exp_en = 4'b0010; vecs[0].exp_pend = 32'h0000_0020;
    vecs[1].valid = 4'b1111;
    vecs[1].rd[0] = 5'd1; vecs[1].rd[1] = 5'd2; vecs[1].rd[2] = 5'd3; vecs[1].rd[3] = 5'd4;
    vecs[1].data[0] = 32'hA; vecs[1].data[1] = 32'hB; vecs[1].data[2] = 32'hC; vecs[1].data[3] = 32'hD;
    vecs[1].exp_en = 4'b1111; vecs[1].exp_pend = 32'h0000_001E;
    vecs[2].valid = 4'b0100; vecs[2].rd[2] = 5'd0; vecs[2].data[2] = 32'hFFFF;
    vecs[2].exp_en = 4'b0000; vecs[2].exp_pend = 32'h0;
    vecs[3].valid = 4'b1001; vecs[3].rd[0] = 5'd31; vecs[3].data[0] = 32'hDEADBEEF;
    vecs[3].rd[3] = 5'd30; vecs[3].data[3] = 32'h12345678;
    vecs[3].exp_en = 4'b1001; vecs[3].exp_pend = 32'hC000_0000;
    vecs[4].valid = 4'b1111; vecs[4].rd[0] = 5'd0; vecs[4].rd[1] = 5'd8; vecs[4].rd[2] = 5'd0;
    vecs[4].rd[3] = 5'd16; vecs[4].data[0] = 32'h1; vecs[4].data[1] = 32'h2;
    vecs[4].data[2] = 32'h3; vecs[4].data[3] = 32'h4;
    vecs[4].exp_en = 4'b1010; vecs[4].exp_pend = 32'h0001_0100;

    idle_inputs();
    #1;
    chk("reset_ready", {28'd0, res_ready}, 32'h0);
    chk("reset_wr_en", {28'd0, wr_en}, 32'h0);
    chk("reset_pending", pending_mask, 32'h0);
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("reset_rd%0d", l), {27'd0, rd_o[l]}, 32'h0);
      chk($sformatf("reset_data%0d", l), data_o[l], 32'h0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 chk("ready_after_reset", {28'd0, res_ready}, 32'hF);
`ifdef WB_CONFLICT_CNT_EN
    chk("conflict_cnt_reset", {16'd0, conflict_cnt}, 32'h0);
`endif

    // Table-driven single bundles.
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      res_valid = vecs[v].valid;
      for (int l = 0; l < 4; l++) begin
        res_rd[l] = vecs[v].rd[l];
        res_data[l] = vecs[v].data[l];
      end
      @(negedge clk);
      idle_inputs();
      chk($sformatf("v%0d_pend_acc", v), pending_mask, vecs[v].exp_pend);
      chk($sformatf("v%0d_ready", v), {28'd0, res_ready}, 32'hF);
      @(negedge clk);
      chk($sformatf("v%0d_wr_en", v), {28'd0, wr_en}, {28'd0, vecs[v].exp_en});
      for (int l = 0; l < 4; l++) begin
        if (vecs[v].exp_en[l]) begin
          chk($sformatf("v%0d_rd%0d", v, l), {27'd0, rd_o[l]}, {27'd0, vecs[v].rd[l]});
          chk($sformatf("v%0d_data%0d", v, l), data_o[l], vecs[v].data[l]);
        end
      end
      chk($sformatf("v%0d_pend_iss", v), pending_mask, vecs[v].exp_pend);
      @(negedge clk);
      chk($sformatf("v%0d_wr_en_off", v), {28'd0, wr_en}, 32'h0);
      chk($sformatf("v%0d_pend_clr", v), pending_mask, 32'h0);
    end
    chk("reg_b_written", regs[2], 32'hB);
    chk("reg31_written", regs[31], 32'hDEADBEEF);

    // lsu and branch collide on rd 7.
    @(negedge clk);
    res_valid = 4'b1001;
    res_rd[0] = 5'd7; res_data[0] = 32'h1;
    res_rd[3] = 5'd7; res_data[3] = 32'h2;
    @(negedge clk);
    idle_inputs();
    chk("col_pend_acc", pending_mask, 32'h80);
    @(negedge clk);
    chk("col_c_wr_en", {28'd0, wr_en}, 32'h1);
    chk("col_c_data", data_o[0], 32'h1);
    chk("col_c_rd", {27'd0, rd_o[0]}, 32'd7);
    @(negedge clk);
    chk("col_c1_wr_en", {28'd0, wr_en}, 32'h8);
    chk("col_c1_data", data_o[3], 32'h2);
    chk("col_c1_pend", pending_mask, 32'h80);
    @(negedge clk);
    chk("col_reg7", regs[7], 32'h2);
    chk("col_pend_clr", pending_mask, 32'h0);
`ifdef WB_CONFLICT_CNT_EN
    chk("conflict_cnt_one", {16'd0, conflict_cnt}, 32'd1);
`endif

    // Single-lane back-to-back throughput.
    clear_log();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("tp_ready%0d", i), {31'd0, res_ready[1]}, 32'd1);
      res_valid = 4'b0010; res_rd[1] = 5'(20 + i); res_data[1] = 32'h200 + i;
    end
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("tp_count", log_lane.size(), 32'd4);
    if (log_lane.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("tp_rd%0d", i), {27'd0, log_rd[i]}, 32'(20 + i));
        chk($sformatf("tp_data%0d", i), log_data[i], 32'h200 + i);
        if (i > 0) chk($sformatf("tp_gap%0d", i), log_cyc[i] - log_cyc[i-1], 32'd1);
      end
    end

    // Four-way collision on rd 9, three bundles per lane.
    clear_log();
    exp_lane.delete(); exp_data.delete();
    for (int l = 0; l < 4; l++) begin
      idx[l] = 0;
      for (int b = 0; b < 3; b++) begin
        exp_lane.push_back(l);
        exp_data.push_back(32'h100 * l + b);
      end
    end
    ready_low_seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      for (int l = 0; l < 4; l++) begin
        res_valid[l] = (idx[l] < 3);
        res_rd[l] = 5'd9;
        res_data[l] = 32'h100 * l + idx[l];
      end
      #1;
      if (res_ready[3] == 1'b0) ready_low_seen = 1'b1;
      @(posedge clk);
      for (int l = 0; l < 4; l++) if (res_valid[l] && res_ready[l]) idx[l]++;
      if (log_lane.size() >= 12) break;
    end
    @(negedge clk);
    idle_inputs();
    chk("c4_all_pushed", idx[0] + idx[1] + idx[2] + idx[3], 32'd12);
    chk("c4_ready_dropped", {31'd0, ready_low_seen}, 32'd1);
    chk("c4_write_count", log_lane.size(), 32'd12);
    if (log_lane.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        chk($sformatf("c4_lane%0d", i), log_lane[i], exp_lane[i]);
        chk($sformatf("c4_data%0d", i), log_data[i], exp_data[i]);
      end
    end
    chk("c4_reg9", regs[9], 32'h302);
    repeat (2) @(negedge clk);
    chk("c4_pend_clr", pending_mask, 32'h0);

    // Reset with results still buffered.
    @(negedge clk);
    res_valid = 4'b1111;
    for (int l = 0; l < 4; l++) begin
      res_rd[l] = 5'd12; res_data[l] = 32'h500 + l;
    end
    @(negedge clk);
    @(negedge clk);
    idle_inputs();
    chk("rstmid_pend_before", pending_mask, 32'h1000);
    rst = 1'b1;
    #1;
    clear_log();
    chk("rstmid_wr_en", {28'd0, wr_en}, 32'h0);
    chk("rstmid_ready", {28'd0, res_ready}, 32'h0);
    chk("rstmid_pend", pending_mask, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rstmid_no_writes", log_lane.size(), 32'd0);
    chk("rstmid_pend_after", pending_mask, 32'h0);
    chk("rstmid_ready_after", {28'd0, res_ready}, 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
